// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte streams.
// Grants are held for a whole packet, capped at MAX_BURST bytes per grant.
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   tx_valid,
  output logic [7:0]             tx_data,
  input  logic                   tx_ready,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  state_e               state_q;
  logic [NUM_REQ-1:0]   grant_q;
  logic [IW-1:0]        last_idx_q;
  logic [CW-1:0]        cnt_q;
  logic                 busy_q;

  logic [IW-1:0]        owner;
  logic                 own_valid;
  logic                 own_last;
  logic [7:0]           own_data;
  logic                 xfer;
  logic [CW-1:0]        cnt_d;
  logic                 burst_hit;
  logic                 release_w;
  logic                 pick_found;
  logic [IW-1:0]        pick_idx;
  logic [NUM_REQ-1:0]   grant_d;
  logic [IW:0]          scan;

  always_comb begin
    owner     = '0;
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        owner     = IW'(i);
        own_valid = req_valid[i];
        own_last  = req_last[i];
        own_data  = req_data[8*i +: 8];
      end
    end
  end

  assign tx_valid  = own_valid;
  assign tx_data   = own_valid ? own_data : 8'h00;
  assign req_ready = grant_q & {NUM_REQ{tx_ready}};
  assign grant     = grant_q;
  assign busy      = busy_q;

  assign xfer      = own_valid & tx_ready;
  assign cnt_d     = cnt_q + CW'(1);
  assign burst_hit = (MAX_BURST != 0) && (cnt_d == CW'(MAX_BURST));
  assign release_w = xfer & (own_last | burst_hit);

  // Scan starts one past the previous owner so every requester gets a turn.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan = {1'b0, last_idx_q} + (IW+1)'(k);
      if (scan >= (IW+1)'(NUM_REQ)) begin
        scan = scan - (IW+1)'(NUM_REQ);
      end
      if (!pick_found && req_valid[scan[IW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = scan[IW-1:0];
      end
    end
  end

  assign grant_d = NUM_REQ'(1) << pick_idx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      last_idx_q <= IW'(NUM_REQ - 1);
      cnt_q      <= '0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable && pick_found) begin
            state_q <= GRANT;
            grant_q <= grant_d;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        GRANT: begin
          if (xfer) begin
            cnt_q <= cnt_d;
          end
          if (release_w) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            last_idx_q <= owner;
            busy_q     <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-requester byte queues feed the DUT,
// a negedge monitor logs accepted bytes, and each test task checks inline.
module tb_uart_tx_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           enable;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           tx_valid;
  logic [7:0]     tx_data;
  logic           tx_ready;
  logic [N-1:0]   grant;
  logic           busy;

  int total = 0;
  int bad   = 0;

  logic [8:0]  mem [N][64];
  int          head [N];
  int          tail [N];
  logic [N-1:0] hold;
  logic [N-1:0] acc_s;
  int          mode;
  int          cyc;
  logic [11:0] log_q [$];

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .MAX_BURST(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .grant     (grant),
    .busy      (busy)
  );

  always @(negedge clk) begin
    acc_s <= req_valid & req_ready;
    if (tx_valid && tx_ready) log_q.push_back({grant, tx_data});
  end

  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    for (int i = 0; i < N; i++) begin
      if (acc_s[i]) head[i] = head[i] + 1;
      if (head[i] < tail[i] && !hold[i]) begin
        req_valid[i]      = 1'b1;
        req_data[8*i +: 8] = mem[i][head[i]][7:0];
        req_last[i]       = mem[i][head[i]][8];
      end else begin
        req_valid[i]      = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]       = 1'b0;
      end
    end
    case (mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = (cyc % 3 == 2);
      default: tx_ready = 1'b0;
    endcase
  end

  task automatic push(input int i, input logic [7:0] d, input logic l);
    mem[i][tail[i]] = {l, d};
    tail[i] = tail[i] + 1;
  endtask

  function automatic bit all_empty();
    bit e;
    e = 1'b1;
    for (int i = 0; i < N; i++) if (head[i] != tail[i]) e = 1'b0;
    return e;
  endfunction

  task automatic drain(input string name);
    bit done;
    done = 1'b0;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      if (all_empty() && !busy) begin
        done = 1'b1;
        break;
      end
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL %s_drain timeout busy=%b", name, busy);
    end
  endtask

  task automatic wait_xfer(input logic [7:0] d, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (tx_valid && tx_ready && tx_data == d) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [3:0] eg;
    logic [11:0] e;
    mode = 0;
    @(posedge clk); #2;
    reset = 1'b0;
    for (int i = 0; i < N; i++) push(i, 8'(8'hA0 + i), 1'b1);
    @(posedge clk);
    @(negedge clk);
    total++;
    if (tx_valid !== 1'b0) begin bad++; $display("FAIL rst_tx_valid got=%b exp=0", tx_valid); end
    total++;
    if (grant !== 4'b0000) begin bad++; $display("FAIL rst_grant got=%b exp=0000", grant); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++;
    if (req_ready !== 4'b0000) begin bad++; $display("FAIL rst_req_ready got=%b exp=0000", req_ready); end
    @(posedge clk); #2;
    reset = 1'b1;
    log_q.delete();
    @(posedge clk);
    @(negedge clk);
    total++;
    if (grant !== 4'b0001) begin bad++; $display("FAIL rst_first_grant got=%b exp=0001", grant); end
    total++;
    if ({busy, tx_valid, tx_data} !== {1'b1, 1'b1, 8'hA0}) begin
      bad++;
      $display("FAIL rst_first_byte got=%b%b %h exp=11 a0", busy, tx_valid, tx_data);
    end
    drain("rst");
    for (int k = 0; k < 4; k++) begin
      eg = 4'b0001 << k;
      e  = {eg, 8'(8'hA0 + k)};
      total++;
      if (k >= log_q.size() || log_q[k] !== e) begin
        bad++;
        $display("FAIL rst_order[%0d] got=%h exp=%h", k, (k < log_q.size()) ? log_q[k] : 12'hxxx, e);
      end
    end
  endtask

  task automatic test_single();
    bit ok;
    bit seen;
    logic [7:0] exp_d [3];
    exp_d[0] = 8'h41; exp_d[1] = 8'h42; exp_d[2] = 8'h43;
    @(negedge clk);
    log_q.delete();
    mode = 2;
    push(2, 8'h41, 1'b0);
    push(2, 8'h42, 1'b0);
    push(2, 8'h43, 1'b1);
    seen = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (busy) begin seen = 1'b1; break; end
    end
    total++;
    if (!seen) begin bad++; $display("FAIL single_busy timeout busy=%b", busy); end
    total++;
    if ({grant, tx_valid, tx_data} !== {4'b0100, 1'b1, 8'h41}) begin
      bad++;
      $display("FAIL single_grant got=%b %b %h exp=0100 1 41", grant, tx_valid, tx_data);
    end
    repeat (50) @(negedge clk);
    total++;
    if (log_q.size() != 0 || grant !== 4'b0100) begin
      bad++;
      $display("FAIL single_stall got log=%0d grant=%b exp log=0 grant=0100", log_q.size(), grant);
    end
    mode = 1;
    wait_xfer(8'h43, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL single_last timeout got=0 exp=1"); end
    @(negedge clk);
    total++;
    if ({busy, grant} !== {1'b0, 4'b0000}) begin
      bad++;
      $display("FAIL single_release got=%b %b exp=0 0000", busy, grant);
    end
    mode = 0;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (k >= log_q.size() || log_q[k] !== {4'b0100, exp_d[k]}) begin
        bad++;
        $display("FAIL single_byte[%0d] got=%h exp=%h", k, (k < log_q.size()) ? log_q[k] : 12'hxxx, {4'b0100, exp_d[k]});
      end
    end
  endtask

  task automatic test_fairness();
    logic [3:0] eg;
    logic       eb;
    int         r;
    @(posedge clk); #2;
    reset = 1'b0;
    mode  = 0;
    for (int i = 0; i < N; i++) begin
      push(i, 8'(8'hA0 + i), 1'b1);
      push(i, 8'(8'hA0 + i), 1'b1);
    end
    @(posedge clk); #2;
    reset = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      r  = (k / 2) % 4;
      eb = (k % 2 == 0);
      eg = eb ? (4'b0001 << r) : 4'b0000;
      total++;
      if ({busy, grant} !== {eb, eg}) begin
        bad++;
        $display("FAIL fair_cyc[%0d] got=%b %b exp=%b %b", k, busy, grant, eb, eg);
      end
      if (eb) begin
        total++;
        if (tx_data !== 8'(8'hA0 + r)) begin
          bad++;
          $display("FAIL fair_data[%0d] got=%h exp=%h", k, tx_data, 8'(8'hA0 + r));
        end
      end
    end
    drain("fair");
  endtask

  task automatic test_lock();
    bit ok;
    logic [11:0] e [4];
    e[0] = {4'b0010, 8'h10};
    e[1] = {4'b0010, 8'h11};
    e[2] = {4'b0010, 8'h12};
    e[3] = {4'b0001, 8'h55};
    @(negedge clk);
    log_q.delete();
    mode = 0;
    push(1, 8'h10, 1'b0);
    push(1, 8'h11, 1'b0);
    push(1, 8'h12, 1'b1);
    wait_xfer(8'h10, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL lock_first timeout got=0 exp=1"); end
    hold[1] = 1'b1;
    push(0, 8'h55, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++;
      if ({grant, req_ready, tx_valid} !== {4'b0010, 4'b0010, 1'b0}) begin
        bad++;
        $display("FAIL lock_wait[%0d] got=%b %b %b exp=0010 0010 0", k, grant, req_ready, tx_valid);
      end
    end
    hold[1] = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      total++;
      if (grant !== 4'b0010 || req_ready[0] !== 1'b0) begin
        bad++;
        $display("FAIL lock_hold[%0d] got=%b %b exp=0010 0", n, grant, req_ready[0]);
      end
      if (tx_valid && tx_ready && tx_data == 8'h12) begin ok = 1'b1; break; end
    end
    total++;
    if (!ok) begin bad++; $display("FAIL lock_last timeout got=0 exp=1"); end
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL lock_idle got=%b exp=0", busy); end
    @(negedge clk);
    total++;
    if (grant !== 4'b0001) begin bad++; $display("FAIL lock_next got=%b exp=0001", grant); end
    drain("lock");
    for (int k = 0; k < 4; k++) begin
      total++;
      if (k >= log_q.size() || log_q[k] !== e[k]) begin
        bad++;
        $display("FAIL lock_order[%0d] got=%h exp=%h", k, (k < log_q.size()) ? log_q[k] : 12'hxxx, e[k]);
      end
    end
  endtask

  task automatic test_burst();
    logic [11:0] e;
    @(posedge clk); #2;
    reset = 1'b0;
    for (int i = 0; i < 20; i++) push(0, 8'(i), (i == 19));
    push(1, 8'hB1, 1'b1);
    @(posedge clk); #2;
    log_q.delete();
    mode  = 1;
    reset = 1'b1;
    drain("burst");
    mode = 0;
    total++;
    if (log_q.size() != 21) begin
      bad++;
      $display("FAIL burst_count got=%0d exp=21", log_q.size());
    end
    for (int k = 0; k < 21; k++) begin
      if (k < 16)       e = {4'b0001, 8'(k)};
      else if (k == 16) e = {4'b0010, 8'hB1};
      else              e = {4'b0001, 8'(k - 1)};
      total++;
      if (k >= log_q.size() || log_q[k] !== e) begin
        bad++;
        $display("FAIL burst_byte[%0d] got=%h exp=%h", k, (k < log_q.size()) ? log_q[k] : 12'hxxx, e);
      end
    end
  endtask

  task automatic test_enable();
    bit ok;
    logic [11:0] e [5];
    e[0] = {4'b0010, 8'h21};
    e[1] = {4'b0010, 8'h22};
    e[2] = {4'b0010, 8'h23};
    e[3] = {4'b0100, 8'h2E};
    e[4] = {4'b0001, 8'h0E};
    @(negedge clk);
    log_q.delete();
    mode = 0;
    push(1, 8'h21, 1'b0);
    push(1, 8'h22, 1'b0);
    push(1, 8'h23, 1'b1);
    push(0, 8'h0E, 1'b1);
    push(2, 8'h2E, 1'b1);
    wait_xfer(8'h21, ok);
    total++;
    if (!ok || grant !== 4'b0010) begin
      bad++;
      $display("FAIL en_first got=%b %b exp=1 0010", ok, grant);
    end
    enable = 1'b0;
    wait_xfer(8'h23, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL en_complete timeout got=0 exp=1"); end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      total++;
      if ({busy, grant} !== {1'b0, 4'b0000}) begin
        bad++;
        $display("FAIL en_off[%0d] got=%b %b exp=0 0000", k, busy, grant);
      end
    end
    enable = 1'b1;
    @(negedge clk);
    total++;
    if (grant !== 4'b0100) begin bad++; $display("FAIL en_resume got=%b exp=0100", grant); end
    drain("en");
    for (int k = 0; k < 5; k++) begin
      total++;
      if (k >= log_q.size() || log_q[k] !== e[k]) begin
        bad++;
        $display("FAIL en_order[%0d] got=%h exp=%h", k, (k < log_q.size()) ? log_q[k] : 12'hxxx, e[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    logic [11:0] e [4];
    e[0] = {4'b0001, 8'h0F};
    e[1] = {4'b1000, 8'h31};
    e[2] = {4'b1000, 8'h32};
    e[3] = {4'b1000, 8'h33};
    @(negedge clk);
    mode = 2;
    push(3, 8'h31, 1'b0);
    push(3, 8'h32, 1'b0);
    push(3, 8'h33, 1'b1);
    seen = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (busy) begin seen = 1'b1; break; end
    end
    total++;
    if (!seen || {grant, tx_valid} !== {4'b1000, 1'b1}) begin
      bad++;
      $display("FAIL rmid_grant got=%b %b %b exp=1 1000 1", seen, grant, tx_valid);
    end
    #2;
    reset = 1'b0;
    #1;
    total++;
    if ({tx_valid, grant, busy, req_ready, tx_data} !== {1'b0, 4'b0000, 1'b0, 4'b0000, 8'h00}) begin
      bad++;
      $display("FAIL rmid_async got=%b %b %b %b %h exp=0 0000 0 0000 00",
               tx_valid, grant, busy, req_ready, tx_data);
    end
    push(0, 8'h0F, 1'b1);
    @(posedge clk); #2;
    reset = 1'b1;
    mode  = 0;
    log_q.delete();
    @(posedge clk);
    @(negedge clk);
    total++;
    if (grant !== 4'b0001) begin bad++; $display("FAIL rmid_first got=%b exp=0001", grant); end
    drain("rmid");
    for (int k = 0; k < 4; k++) begin
      total++;
      if (k >= log_q.size() || log_q[k] !== e[k]) begin
        bad++;
        $display("FAIL rmid_order[%0d] got=%h exp=%h", k, (k < log_q.size()) ? log_q[k] : 12'hxxx, e[k]);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b0;
    enable    = 1'b1;
    tx_ready  = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    hold      = '0;
    acc_s     = '0;
    mode      = 0;
    cyc       = 0;
    for (int i = 0; i < N; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    test_reset();
    test_single();
    test_fairness();
    test_lock();
    test_burst();
    test_enable();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
